// File: rtl/axis_to_axi4_wr_burst.sv
// rtl/axis_to_axi4_wr_burst.sv - tlast-framed AXI-Stream to AXI4 INCR write bursts, split at a beat cap and 4KB
// Bursts are described before AW is issued, so awlen is exact; W data waits in a beat FIFO behind its AW.

module axis_wr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

module axis_to_axi4_wr_burst #(
  parameter int DSIZE           = 64,
  parameter int ASIZE           = 32,
  parameter int IDSIZE          = 1,
  parameter int MAX_BURST       = 128,
  parameter int FIFO_DEPTH      = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [ASIZE-1:0]   base_addr,
  input  logic [8:0]         burst_beats,
  input  logic [DSIZE-1:0]   axis_in_tdata,
  input  logic               axis_in_tvalid,
  output logic               axis_in_tready,
  input  logic               axis_in_tlast,
  output logic [IDSIZE-1:0]  axi_wr_awid,
  output logic [ASIZE-1:0]   axi_wr_awaddr,
  output logic [7:0]         axi_wr_awlen,
  output logic [2:0]         axi_wr_awsize,
  output logic [1:0]         axi_wr_awburst,
  output logic               axi_wr_awvalid,
  input  logic               axi_wr_awready,
  output logic [DSIZE-1:0]   axi_wr_wdata,
  output logic [DSIZE/8-1:0] axi_wr_wstrb,
  output logic               axi_wr_wlast,
  output logic               axi_wr_wvalid,
  input  logic               axi_wr_wready,
  input  logic [1:0]         axi_wr_bresp,
  input  logic               axi_wr_bvalid,
  output logic               axi_wr_bready,
  output logic               frame_done,
  output logic               err,
  output logic               busy
);
  localparam int BSHIFT = $clog2(DSIZE / 8);
  localparam int DW     = ASIZE + 9;
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {AW_IDLE, AW_REQ} aw_state_t;
  typedef enum logic {W_IDLE, W_DATA} w_state_t;

  logic              run_q, run_d, frame_start_q, frame_start_d;
  logic [ASIZE-1:0]  cur_addr_q, cur_addr_d;
  logic [8:0]        cap_q, cap_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ASIZE-1:0]  burst_addr;
  logic [8:0]        cap_in, burst_cap, limit;
  logic [12:0]       bytes_left, beats_left;
  logic              closing, beat_acc;

  logic              data_full, data_empty;
  logic [DSIZE-1:0]  data_dout;
  logic              desc_full, desc_empty, desc_pop;
  logic [DW-1:0]     desc_dout;
  logic              wq_full, wq_empty, wq_pop;
  logic [7:0]        wq_dout;
  logic              bq_full, bq_empty;
  logic [0:0]        bq_dout;

  aw_state_t         aw_state_q, aw_state_d;
  logic [ASIZE-1:0]  aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic              aw_last_q, aw_last_d, aw_fire;
  logic [OW-1:0]     outstanding_q, outstanding_d;

  w_state_t          w_state_q, w_state_d;
  logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic              w_fire, w_last;
  logic              b_fire, err_q, err_d;

  // Limit is re-derived every beat from the burst's start address; it is constant within a burst.
  always_comb begin
    cap_in     = (burst_beats == 9'd0 || burst_beats > 9'(MAX_BURST)) ? 9'(MAX_BURST) : burst_beats;
    burst_addr = frame_start_q ? base_addr : cur_addr_q;
    burst_cap  = frame_start_q ? cap_in : cap_q;
    bytes_left = 13'h1000 - {1'b0, burst_addr[11:0]};
    beats_left = bytes_left >> BSHIFT;
    limit      = (beats_left < {4'd0, burst_cap}) ? beats_left[8:0] : burst_cap;
    closing    = axis_in_tlast || (({1'b0, beat_cnt_q} + 9'd1) == limit);
  end

  assign axis_in_tready = run_q && !data_full && !(closing && desc_full);
  assign beat_acc       = axis_in_tvalid && axis_in_tready;

  always_comb begin
    run_d         = 1'b1;
    frame_start_d = frame_start_q;
    cur_addr_d    = cur_addr_q;
    cap_d         = cap_q;
    beat_cnt_d    = beat_cnt_q;
    if (beat_acc) begin
      frame_start_d = axis_in_tlast;
      cap_d         = burst_cap;
      if (closing) begin
        cur_addr_d = burst_addr + (ASIZE'({1'b0, beat_cnt_q} + 9'd1) << BSHIFT);
        beat_cnt_d = '0;
      end else begin
        cur_addr_d = burst_addr;
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end
  end

  axis_wr_sync_fifo #(.WIDTH(DSIZE), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk(clock), .rst_n(rst_n), .push(beat_acc), .din(axis_in_tdata),
    .pop(w_fire), .dout(data_dout), .full(data_full), .empty(data_empty)
  );

  axis_wr_sync_fifo #(.WIDTH(DW), .DEPTH(MAX_OUTSTANDING)) u_desc_fifo (
    .clk(clock), .rst_n(rst_n), .push(beat_acc && closing),
    .din({burst_addr, beat_cnt_q, axis_in_tlast}),
    .pop(desc_pop), .dout(desc_dout), .full(desc_full), .empty(desc_empty)
  );

  axis_wr_sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_w_fifo (
    .clk(clock), .rst_n(rst_n), .push(aw_fire), .din(aw_len_q),
    .pop(wq_pop), .dout(wq_dout), .full(wq_full), .empty(wq_empty)
  );

  axis_wr_sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_b_fifo (
    .clk(clock), .rst_n(rst_n), .push(aw_fire), .din(aw_last_q),
    .pop(b_fire), .dout(bq_dout), .full(bq_full), .empty(bq_empty)
  );

  assign aw_fire = (aw_state_q == AW_REQ) && axi_wr_awready;
  assign b_fire  = axi_wr_bvalid && axi_wr_bready;

  always_comb begin
    aw_state_d    = aw_state_q;
    aw_addr_d     = aw_addr_q;
    aw_len_d      = aw_len_q;
    aw_last_d     = aw_last_q;
    desc_pop      = 1'b0;
    outstanding_d = outstanding_q;
    case (aw_state_q)
      AW_IDLE: begin
        if (!desc_empty && outstanding_q < OW'(MAX_OUTSTANDING) && !wq_full && !bq_full) begin
          desc_pop                          = 1'b1;
          {aw_addr_d, aw_len_d, aw_last_d} = desc_dout;
          aw_state_d                        = AW_REQ;
        end
      end
      AW_REQ:  if (axi_wr_awready) aw_state_d = AW_IDLE;
      default: aw_state_d = AW_IDLE;
    endcase
    if (aw_fire && !b_fire) outstanding_d = outstanding_q + OW'(1);
    else if (!aw_fire && b_fire && outstanding_q != '0) outstanding_d = outstanding_q - OW'(1);
  end

  assign w_fire = axi_wr_wvalid && axi_wr_wready;
  assign w_last = (w_state_q == W_DATA) && (wbeat_q == wlen_q);

  // A finished burst hands straight over to the next queued one to avoid an idle beat.
  always_comb begin
    w_state_d = w_state_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wq_pop    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!wq_empty) begin
          wq_pop    = 1'b1;
          wlen_d    = wq_dout;
          wbeat_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          if (w_last) begin
            if (!wq_empty) begin
              wq_pop  = 1'b1;
              wlen_d  = wq_dout;
              wbeat_d = '0;
            end else begin
              w_state_d = W_IDLE;
            end
          end else begin
            wbeat_d = wbeat_q + 8'd1;
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign err_d = err_q || (b_fire && axi_wr_bresp != 2'b00);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      frame_start_q <= 1'b1;
      cur_addr_q    <= '0;
      cap_q         <= '0;
      beat_cnt_q    <= '0;
      aw_state_q    <= AW_IDLE;
      aw_addr_q     <= '0;
      aw_len_q      <= '0;
      aw_last_q     <= 1'b0;
      outstanding_q <= '0;
      w_state_q     <= W_IDLE;
      wlen_q        <= '0;
      wbeat_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      run_q         <= run_d;
      frame_start_q <= frame_start_d;
      cur_addr_q    <= cur_addr_d;
      cap_q         <= cap_d;
      beat_cnt_q    <= beat_cnt_d;
      aw_state_q    <= aw_state_d;
      aw_addr_q     <= aw_addr_d;
      aw_len_q      <= aw_len_d;
      aw_last_q     <= aw_last_d;
      outstanding_q <= outstanding_d;
      w_state_q     <= w_state_d;
      wlen_q        <= wlen_d;
      wbeat_q       <= wbeat_d;
      err_q         <= err_d;
    end
  end

  assign axi_wr_awid    = '0;
  assign axi_wr_awaddr  = aw_addr_q;
  assign axi_wr_awlen   = aw_len_q;
  assign axi_wr_awsize  = 3'(BSHIFT);
  assign axi_wr_awburst = 2'b01;
  assign axi_wr_awvalid = (aw_state_q == AW_REQ);
  assign axi_wr_wdata   = data_dout;
  assign axi_wr_wstrb   = '1;
  assign axi_wr_wvalid  = (w_state_q == W_DATA) && !data_empty;
  assign axi_wr_wlast   = w_last;
  assign axi_wr_bready  = run_q;
  assign frame_done     = b_fire && !bq_empty && bq_dout[0];
  assign err            = err_q;
  assign busy           = !data_empty || (beat_cnt_q != '0) || !desc_empty ||
                          (aw_state_q != AW_IDLE) || (outstanding_q != '0) || (w_state_q != W_IDLE);
endmodule

// File: tb/tb_axis_to_axi4_wr_burst.sv
// tb/tb_axis_to_axi4_wr_burst.sv - directed self-checking bench for axis_to_axi4_wr_burst
module tb_axis_to_axi4_wr_burst;
  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] base_addr;
  logic [8:0]  burst_beats;
  logic [63:0] axis_in_tdata;
  logic        axis_in_tvalid, axis_in_tready, axis_in_tlast;
  logic [0:0]  axi_wr_awid;
  logic [31:0] axi_wr_awaddr;
  logic [7:0]  axi_wr_awlen;
  logic [2:0]  axi_wr_awsize;
  logic [1:0]  axi_wr_awburst;
  logic        axi_wr_awvalid, axi_wr_awready;
  logic [63:0] axi_wr_wdata;
  logic [7:0]  axi_wr_wstrb;
  logic        axi_wr_wlast, axi_wr_wvalid, axi_wr_wready;
  logic [1:0]  axi_wr_bresp;
  logic        axi_wr_bvalid, axi_wr_bready;
  logic        frame_done, err, busy;

  always #5 clock = ~clock;

  axis_to_axi4_wr_burst dut (
    .clock(clock), .rst_n(rst_n), .base_addr(base_addr), .burst_beats(burst_beats),
    .axis_in_tdata(axis_in_tdata), .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tready(axis_in_tready), .axis_in_tlast(axis_in_tlast),
    .axi_wr_awid(axi_wr_awid), .axi_wr_awaddr(axi_wr_awaddr), .axi_wr_awlen(axi_wr_awlen),
    .axi_wr_awsize(axi_wr_awsize), .axi_wr_awburst(axi_wr_awburst),
    .axi_wr_awvalid(axi_wr_awvalid), .axi_wr_awready(axi_wr_awready),
    .axi_wr_wdata(axi_wr_wdata), .axi_wr_wstrb(axi_wr_wstrb), .axi_wr_wlast(axi_wr_wlast),
    .axi_wr_wvalid(axi_wr_wvalid), .axi_wr_wready(axi_wr_wready),
    .axi_wr_bresp(axi_wr_bresp), .axi_wr_bvalid(axi_wr_bvalid), .axi_wr_bready(axi_wr_bready),
    .frame_done(frame_done), .err(err), .busy(busy)
  );

  int checks = 0, failures = 0;
  int aw_cnt, b_cnt, fd_cnt, fd_last_b, w_cnt, wb_idx, wb_beat, b_pending, max_out;
  int attr_err, order_err, wlast_err, fd_bad, err_burst;
  logic [31:0] aw_addr_log [64];
  logic [7:0]  aw_len_log [64];
  logic [63:0] w_log [$];
  logic [63:0] exp_log [$];
  bit aw_ready_en, b_hold, abort, tready_low_seen;

  // Slave model: drives on the falling edge, samples handshakes just before the rising edge.
  always begin
    @(negedge clock);
    axi_wr_awready = aw_ready_en;
    axi_wr_wready  = 1'b1;
    axi_wr_bvalid  = rst_n && (b_pending > 0) && !b_hold;
    axi_wr_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
    #4;
    if (!rst_n) begin
      b_pending = 0;
    end else begin
      if (axi_wr_wvalid && axi_wr_wready) begin
        if (wb_idx >= aw_cnt || wb_idx >= 64) order_err++;
        else if (axi_wr_wlast !== (wb_beat == int'(aw_len_log[wb_idx]))) wlast_err++;
        if (axi_wr_wstrb !== 8'hFF) attr_err++;
        w_log.push_back(axi_wr_wdata);
        w_cnt++;
        if (axi_wr_wlast) begin
          wb_idx++;
          wb_beat = 0;
          b_pending++;
        end else begin
          wb_beat++;
        end
      end
      if (axi_wr_awvalid && axi_wr_awready) begin
        if (axi_wr_awsize !== 3'd3 || axi_wr_awburst !== 2'b01 || axi_wr_awid !== 1'b0) attr_err++;
        if (aw_cnt < 64) begin
          aw_addr_log[aw_cnt] = axi_wr_awaddr;
          aw_len_log[aw_cnt]  = axi_wr_awlen;
        end
        aw_cnt++;
      end
      if (axi_wr_bvalid && axi_wr_bready) begin
        b_cnt++;
        b_pending--;
      end
      if (frame_done) begin
        if (!(axi_wr_bvalid && axi_wr_bready)) fd_bad++;
        fd_cnt++;
        fd_last_b = b_cnt;
      end
      if (aw_cnt - b_cnt > max_out) max_out = aw_cnt - b_cnt;
    end
  end

  function automatic int data_mism();
    int m = 0;
    if (w_log.size() != exp_log.size()) return 1000000;
    foreach (w_log[k]) if (w_log[k] !== exp_log[k]) m++;
    return m;
  endfunction

  function automatic int proto_errs();
    return attr_err + order_err + wlast_err + fd_bad;
  endfunction

  task automatic clear_logs();
    aw_cnt = 0; b_cnt = 0; fd_cnt = 0; fd_last_b = 0; w_cnt = 0; wb_idx = 0; wb_beat = 0;
    max_out = 0; attr_err = 0; order_err = 0; wlast_err = 0; fd_bad = 0;
    tready_low_seen = 0;
    w_log.delete();
    exp_log.delete();
  endtask

  task automatic send_frame(input logic [31:0] base, input logic [8:0] bb, input int n, input int fid);
    int waits;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (abort) begin axis_in_tvalid = 1'b0; return; end
      axis_in_tvalid = 1'b1;
      axis_in_tdata  = {32'(fid), 32'(i)};
      axis_in_tlast  = (i == n - 1);
      base_addr      = (i == 0) ? base : 32'hDEAD_BEE0;
      burst_beats    = (i == 0) ? bb : 9'd2;
      waits = 0;
      #4;
      while (!axis_in_tready) begin
        tready_low_seen = 1;
        @(negedge clock);
        #4;
        waits++;
        if (abort) begin axis_in_tvalid = 1'b0; return; end
        if (waits > 5000) begin
          checks++; failures++;
          $display("FAIL send_timeout frame=%0d beat=%0d tready=0 required=1", fid, i);
          axis_in_tvalid = 1'b0;
          return;
        end
      end
      exp_log.push_back(axis_in_tdata);
    end
    @(negedge clock);
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      #3;
      n++;
    end while ((busy || b_pending != 0) && n < 20000);
    checks++;
    if (busy || b_pending != 0) begin
      failures++;
      $display("FAIL %s_idle busy=%0b pending_b=%0d required 0/0", name, busy, b_pending);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0; axis_in_tdata = '0;
    base_addr = '0; burst_beats = '0; aw_ready_en = 1; b_hold = 0; abort = 0; err_burst = -1;
    clear_logs();
    repeat (3) @(negedge clock);
    #3;
    checks++;
    if ({axi_wr_awvalid, axi_wr_wvalid, axi_wr_wlast, axi_wr_bready, axis_in_tready, frame_done, err, busy} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=00000000",
               {axi_wr_awvalid, axi_wr_wvalid, axi_wr_wlast, axi_wr_bready, axis_in_tready, frame_done, err, busy});
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    #3;
    checks++;
    if ({axi_wr_bready, axis_in_tready, busy} !== 3'b110) begin
      failures++;
      $display("FAIL post_reset bready/tready/busy got=%b required=110", {axi_wr_bready, axis_in_tready, busy});
    end
  endtask

  task automatic test_long_frame();
    logic [31:0] ea [5];
    logic [7:0]  el [5];
    ea = '{32'h0, 32'h400, 32'h800, 32'hC00, 32'h1000};
    el = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd10};
    clear_logs();
    send_frame(32'h0, 9'd128, 523, 1);
    wait_idle("long");
    checks++;
    if (aw_cnt != 5) begin failures++; $display("FAIL long_aw_count got=%0d required=5", aw_cnt); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (aw_addr_log[k] !== ea[k] || aw_len_log[k] !== el[k]) begin
        failures++;
        $display("FAIL long_aw%0d got=%h/%0d required=%h/%0d", k, aw_addr_log[k], aw_len_log[k], ea[k], el[k]);
      end
    end
    checks++;
    if (data_mism() != 0) begin failures++; $display("FAIL long_data mismatches=%0d beats=%0d required 0/523", data_mism(), w_cnt); end
    checks++;
    if (fd_cnt != 1 || fd_last_b != 5) begin failures++; $display("FAIL long_frame_done got=%0d@b%0d required=1@b5", fd_cnt, fd_last_b); end
    checks++;
    if (proto_errs() != 0) begin failures++; $display("FAIL long_protocol errors=%0d required=0", proto_errs()); end
  endtask

  task automatic test_4k_cross();
    clear_logs();
    send_frame(32'hF80, 9'd128, 40, 2);
    wait_idle("4k");
    checks++;
    if (aw_cnt != 2) begin failures++; $display("FAIL 4k_aw_count got=%0d required=2", aw_cnt); end
    checks++;
    if (aw_addr_log[0] !== 32'hF80 || aw_len_log[0] !== 8'd15) begin
      failures++; $display("FAIL 4k_aw0 got=%h/%0d required=f80/15", aw_addr_log[0], aw_len_log[0]);
    end
    checks++;
    if (aw_addr_log[1] !== 32'h1000 || aw_len_log[1] !== 8'd23) begin
      failures++; $display("FAIL 4k_aw1 got=%h/%0d required=1000/23", aw_addr_log[1], aw_len_log[1]);
    end
    checks++;
    if (data_mism() != 0 || fd_cnt != 1 || proto_errs() != 0) begin
      failures++; $display("FAIL 4k_data_done mism=%0d fd=%0d proto=%0d required 0/1/0", data_mism(), fd_cnt, proto_errs());
    end
  endtask

  task automatic test_single_beat();
    clear_logs();
    send_frame(32'h20, 9'd128, 1, 3);
    wait_idle("single");
    checks++;
    if (aw_cnt != 1 || aw_addr_log[0] !== 32'h20 || aw_len_log[0] !== 8'd0) begin
      failures++; $display("FAIL single_aw got=%0d x %h/%0d required=1 x 20/0", aw_cnt, aw_addr_log[0], aw_len_log[0]);
    end
    checks++;
    if (w_cnt != 1 || data_mism() != 0 || fd_cnt != 1 || proto_errs() != 0) begin
      failures++; $display("FAIL single_w beats=%0d mism=%0d fd=%0d proto=%0d required 1/0/1/0", w_cnt, data_mism(), fd_cnt, proto_errs());
    end
  endtask

  task automatic test_burst_cap();
    logic [31:0] ea [6];
    logic [7:0]  el [6];
    ea = '{32'h100, 32'h180, 32'h200, 32'h300, 32'h2000, 32'h2400};
    el = '{8'd15, 8'd3, 8'd7, 8'd7, 8'd127, 8'd1};
    clear_logs();
    send_frame(32'h100, 9'd16, 20, 4);
    send_frame(32'h200, 9'd0, 8, 5);
    send_frame(32'h300, 9'd8, 8, 6);
    send_frame(32'h2000, 9'd300, 130, 7);
    wait_idle("cap");
    checks++;
    if (aw_cnt != 6) begin failures++; $display("FAIL cap_aw_count got=%0d required=6", aw_cnt); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (aw_addr_log[k] !== ea[k] || aw_len_log[k] !== el[k]) begin
        failures++;
        $display("FAIL cap_aw%0d got=%h/%0d required=%h/%0d", k, aw_addr_log[k], aw_len_log[k], ea[k], el[k]);
      end
    end
    checks++;
    if (data_mism() != 0 || fd_cnt != 4 || proto_errs() != 0) begin
      failures++; $display("FAIL cap_data_done mism=%0d fd=%0d proto=%0d required 0/4/0", data_mism(), fd_cnt, proto_errs());
    end
  endtask

  task automatic test_outstanding();
    clear_logs();
    aw_ready_en = 0;
    b_hold = 1;
    fork
      for (int f = 0; f < 10; f++) send_frame(32'h4000 + 32'(f) * 32'h100, 9'd128, 8, 10 + f);
      begin
        repeat (150) @(negedge clock);
        aw_ready_en = 1;
        repeat (60) @(negedge clock);
        checks++;
        if (aw_cnt - b_cnt != 4) begin failures++; $display("FAIL outst_held got=%0d required=4", aw_cnt - b_cnt); end
        b_hold = 0;
      end
    join
    wait_idle("outst");
    checks++;
    if (tready_low_seen != 1) begin failures++; $display("FAIL outst_backpressure tready_low=%0d required=1", tready_low_seen); end
    checks++;
    if (max_out != 4) begin failures++; $display("FAIL outst_max got=%0d required=4", max_out); end
    checks++;
    if (aw_cnt != 10 || w_cnt != 80 || data_mism() != 0) begin
      failures++; $display("FAIL outst_data aw=%0d beats=%0d mism=%0d required 10/80/0", aw_cnt, w_cnt, data_mism());
    end
    checks++;
    if (fd_cnt != 10 || proto_errs() != 0) begin failures++; $display("FAIL outst_done fd=%0d proto=%0d required 10/0", fd_cnt, proto_errs()); end
  endtask

  task automatic test_slverr();
    clear_logs();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL slverr_pre err=%b required=0", err); end
    err_burst = 1;
    send_frame(32'h0, 9'd4, 12, 30);
    wait_idle("slverr");
    err_burst = -1;
    checks++;
    if (aw_cnt != 3 || err !== 1'b1) begin failures++; $display("FAIL slverr_set aw=%0d err=%b required 3/1", aw_cnt, err); end
    checks++;
    if (fd_cnt != 1 || fd_last_b != 3) begin failures++; $display("FAIL slverr_done got=%0d@b%0d required=1@b3", fd_cnt, fd_last_b); end
    clear_logs();
    send_frame(32'h8, 9'd128, 1, 31);
    wait_idle("slverr2");
    checks++;
    if (err !== 1'b1 || fd_cnt != 1) begin failures++; $display("FAIL slverr_sticky err=%b fd=%0d required 1/1", err, fd_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    fork
      send_frame(32'h0, 9'd32, 64, 40);
      begin
        while (w_cnt < 5 && n < 2000) begin @(negedge clock); n++; end
        checks++;
        if (w_cnt < 5) begin failures++; $display("FAIL rstmid_w_start beats=%0d required>=5", w_cnt); end
        #2;
        rst_n = 1'b0;
        abort = 1;
        #1;
        checks++;
        if ({axi_wr_awvalid, axi_wr_wvalid, axi_wr_wlast, axis_in_tready, axi_wr_bready, busy, err} !== 7'b0) begin
          failures++;
          $display("FAIL rstmid_outputs got=%b required=0000000",
                   {axi_wr_awvalid, axi_wr_wvalid, axi_wr_wlast, axis_in_tready, axi_wr_bready, busy, err});
        end
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
      end
    join
    abort = 0;
    @(negedge clock);
    clear_logs();
    send_frame(32'h40, 9'd128, 16, 41);
    wait_idle("rstmid");
    checks++;
    if (aw_cnt != 1 || aw_addr_log[0] !== 32'h40 || aw_len_log[0] !== 8'd15) begin
      failures++; $display("FAIL rstmid_aw got=%0d x %h/%0d required=1 x 40/15", aw_cnt, aw_addr_log[0], aw_len_log[0]);
    end
    checks++;
    if (w_cnt != 16 || data_mism() != 0 || fd_cnt != 1 || proto_errs() != 0) begin
      failures++; $display("FAIL rstmid_frame beats=%0d mism=%0d fd=%0d proto=%0d required 16/0/1/0", w_cnt, data_mism(), fd_cnt, proto_errs());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout sim_time=%0t required=finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_long_frame();
    test_4k_cross();
    test_single_beat();
    test_burst_cap();
    test_outstanding();
    test_slverr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_to_axi4_wr_burst.md
Name: axis_to_axi4_wr_burst

Overview:
- Parametrised successor to the single-burst stream-to-AXI4 write converter.
- Accepts tlast-delimited AXI-Stream frames and writes each frame to incrementing addresses from a per-frame base address.
- Splits every frame into INCR bursts capped by a runtime beat limit and never crossing a 4KB boundary.
- Buffers data so AW is issued with the exact length, allows several outstanding bursts, and reports per-frame completion and write-response errors.

Parameters:
DSIZE, 64, data width in bits; power of two, 8..1024.
ASIZE, 32, AXI address width.
IDSIZE, 1, AXI ID width; awid is driven to 0.
MAX_BURST, 128, maximum beats per burst, ≤256.
FIFO_DEPTH, 256, data buffer depth in beats; must be ≥ MAX_BURST.
MAX_OUTSTANDING, 4, maximum AW-issued bursts awaiting B.

Ports:
clock  in  1  clock for all logic, shared with both interfaces.
rst_n  in  1  asynchronous active-low reset.
base_addr  in  ASIZE  frame start byte address; sampled on the first beat of each frame; must be DSIZE/8 aligned.
burst_beats  in  9  runtime burst cap, 1..MAX_BURST; sampled with base_addr; 0 or >MAX_BURST is treated as MAX_BURST.
axis_in  slave  axi_stream_inf(DSIZE)  input frames; tdata, tvalid, tready, tlast used.
axi_wr  master_wr  axi_inf(IDSIZE,ASIZE,8,DSIZE)  AW, W and B channels.
frame_done  out  1  one-cycle pulse when the B response for a frame's last burst is accepted.
err  out  1  sticky flag, set on any bresp≠OKAY; cleared only by reset.
busy  out  1  high while any beat is buffered, any burst is open, or any B is pending.

Behaviour:
- Reset: all FIFOs emptied; awvalid=0, wvalid=0, wlast=0, bready=0, tready=0 during reset; frame_done=0, err=0, busy=0. Reset mid-burst abandons everything; no recovery of partial bursts.
- After reset, bready is held at 1.
- Input: tready = data FIFO not full. Each accepted beat is pushed to the data FIFO.
- Burst former:
  - Holds cur_addr, beat_cnt and limit.
  - On the first beat of a frame: cur_addr=base_addr, cap=burst_beats.
  - limit = min(cap, (4096 − cur_addr[11:0]) / (DSIZE/8)).
  - A burst closes when beat_cnt+1==limit or tlast. On close it pushes descriptor {addr=cur_addr, len=beat_cnt, last=tlast} to the descriptor queue (depth MAX_OUTSTANDING).
  - cur_addr += (beat_cnt+1)·DSIZE/8, and beat_cnt is reset.
  - The next burst of the same frame recomputes limit from the new cur_addr.
  - When the descriptor queue is full, tready=0 on any beat that would close a burst.
- AW FSM, states AW_IDLE→AW_REQ→AW_IDLE:
  - Leaves AW_IDLE when the descriptor queue is non-empty and outstanding<MAX_OUTSTANDING.
  - In AW_REQ it drives awaddr/awlen from the descriptor, with awsize=log2(DSIZE/8), awburst=INCR and awid=0.
  - Returns to AW_IDLE on awvalid&awready.
  - The descriptor is copied to the W queue and the B-tracking queue.
  - Outstanding count: +1 on the AW handshake, −1 on the B handshake; both in the same cycle means no change.
- W FSM, states W_IDLE→W_DATA:
  - Starts only for bursts whose AW has completed; W never precedes its AW.
  - wvalid = FIFO non-empty; wstrb all ones; wlast on beat len.
  - Returns to W_IDLE after the wlast handshake. Back-to-back bursts need no idle cycle.
- B handling: bresp≠0 sets err. When the popped tracking entry has last=1, frame_done pulses in that cycle.
- Latency: AW asserted no earlier than 2 cycles after the closing beat is accepted.
- Single-beat frame produces len=0. A limit reached on the same beat as tlast produces one burst with last=1.
- base_addr/burst_beats changes mid-frame are ignored until the next frame.

Test Plan:
- 523-beat frame, base=0, burst_beats=128, DSIZE=64 → AW lens 127,127,127,127,10 at 0x000,0x400,0x800,0xC00,0x1000; 523 W beats with data intact; one frame_done after the 5th B.
- base=0xF80, burst_beats=128, 40-beat frame → len 15 @0xF80 and len 23 @0x1000; no burst crosses 4KB.
- Single-beat frame at 0x20 → awlen=0, wlast on the only beat, frame_done once.
- Slave with awready held low, 10 consecutive 8-beat frames → at most 4 bursts awaiting B; tready deasserts when the FIFO fills; no data lost; 10 frame_done pulses.
- Slave returns SLVERR on burst 2 of 3 → err rises and stays high; frame_done still pulses.
- Assert rst_n low mid-W burst → all valids low immediately, busy=0; a subsequent 16-beat frame completes correctly.
